// File: rtl/biriscv_icache_arb.sv
// Icache read-port arbiter: demand fetch (port 0) vs next-line prefetch (port 1), in-order
// response routing via an owner FIFO, and drained flush/invalidate sequencing.
// Optional fairness (forced port-1 grant after a run of port-0 grants): ICACHE_ARB_FAIRNESS_EN.
module biriscv_icache_arb #(
    parameter int OUTSTANDING_W = 1,
    parameter int STARVE_LIMIT  = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req0_rd_i,
    input  logic [31:0] req0_pc_i,
    input  logic [1:0]  req0_priv_i,
    output logic        req0_accept_o,
    output logic        req0_valid_o,
    input  logic        req1_rd_i,
    input  logic [31:0] req1_pc_i,
    input  logic [1:0]  req1_priv_i,
    output logic        req1_accept_o,
    output logic        req1_valid_o,
    output logic [63:0] resp_inst_o,
    output logic        resp_error_o,
    output logic        resp_page_fault_o,
    input  logic        flush_req_i,
    input  logic        invalidate_req_i,
    output logic        maint_busy_o,
    output logic        icache_rd_o,
    output logic [31:0] icache_pc_o,
    output logic [1:0]  icache_priv_o,
    input  logic        icache_accept_i,
    input  logic        icache_valid_i,
    input  logic [63:0] icache_inst_i,
    input  logic        icache_error_i,
    input  logic        icache_page_fault_i,
    output logic        icache_flush_o,
    output logic        icache_invalidate_o
);
    localparam int DEPTH = 2 ** OUTSTANDING_W;
    localparam logic [1:0] ST_ARB   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_MAINT = 2'd2;
    localparam logic [OUTSTANDING_W-1:0] PTR_ONE = 1;
    localparam logic [OUTSTANDING_W:0]   CNT_ONE = 1;

    logic [1:0]               r_state;
    logic                     r_pend_flush;
    logic                     r_pend_inv;
    logic                     r_lock;
    logic                     r_lock_id;
    logic                     r_owner [DEPTH];
    logic [OUTSTANDING_W-1:0] r_wr_ptr;
    logic [OUTSTANDING_W-1:0] r_rd_ptr;
    logic [OUTSTANDING_W:0]   r_count;

    logic w_maint_req;
    logic w_full;
    logic w_can_issue;
    logic w_force1;
    logic w_pick1;
    logic w_rd;
    logic w_grant;
    logic w_accept;
    logic w_pop;
    logic w_head;

    assign w_maint_req = flush_req_i | invalidate_req_i;
    // Count can only reach DEPTH, so its MSB alone flags a full FIFO.
    assign w_full      = r_count[OUTSTANDING_W];
    assign w_can_issue = (r_state == ST_ARB) & ~w_full & ~w_maint_req & ~r_pend_flush & ~r_pend_inv;
    assign w_pick1     = req1_rd_i & (~req0_rd_i | w_force1);
    assign w_rd        = r_lock | (w_can_issue & (req0_rd_i | req1_rd_i));
    assign w_grant     = r_lock ? r_lock_id : w_pick1;
    assign w_accept    = icache_accept_i & w_rd;
    assign w_pop       = icache_valid_i & (r_count != '0);
    assign w_head      = r_owner[r_rd_ptr];

    assign icache_rd_o   = w_rd;
    assign icache_pc_o   = w_rd ? (w_grant ? req1_pc_i : req0_pc_i) : 32'h0;
    assign icache_priv_o = w_rd ? (w_grant ? req1_priv_i : req0_priv_i) : 2'h0;
    assign req0_accept_o = w_accept & ~w_grant;
    assign req1_accept_o = w_accept & w_grant;

    assign req0_valid_o      = w_pop & ~w_head;
    assign req1_valid_o      = w_pop & w_head;
    assign resp_inst_o       = w_pop ? icache_inst_i : 64'h0;
    assign resp_error_o      = w_pop & icache_error_i;
    assign resp_page_fault_o = w_pop & icache_page_fault_i;

    assign maint_busy_o        = (r_state != ST_ARB) | w_maint_req | r_pend_flush | r_pend_inv;
    assign icache_flush_o      = (r_state == ST_MAINT) & r_pend_flush;
    assign icache_invalidate_o = (r_state == ST_MAINT) & r_pend_inv;

    // Owner storage needs no reset: the pointers define which entries are live.
    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_owner[r_wr_ptr] <= w_grant;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= ST_ARB;
            r_pend_flush <= 1'b0;
            r_pend_inv   <= 1'b0;
            r_lock       <= 1'b0;
            r_lock_id    <= 1'b0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
        end else begin
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            if (w_accept && !w_pop) begin
                r_count <= r_count + CNT_ONE;
            end else if (!w_accept && w_pop) begin
                r_count <= r_count - CNT_ONE;
            end

            // An unaccepted request keeps its winner until the icache takes it.
            if (w_accept) begin
                r_lock <= 1'b0;
            end else if (w_rd && !r_lock) begin
                r_lock    <= 1'b1;
                r_lock_id <= w_grant;
            end

            r_pend_flush <= ((r_state == ST_MAINT) ? 1'b0 : r_pend_flush) | flush_req_i;
            r_pend_inv   <= ((r_state == ST_MAINT) ? 1'b0 : r_pend_inv) | invalidate_req_i;

            case (r_state)
                ST_ARB:   if (w_maint_req || r_pend_flush || r_pend_inv) r_state <= ST_DRAIN;
                ST_DRAIN: if (r_count == '0 && !r_lock) r_state <= ST_MAINT;
                ST_MAINT: r_state <= ST_ARB;
                default:  r_state <= ST_ARB;
            endcase
        end
    end

`ifdef ICACHE_ARB_FAIRNESS_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [SW-1:0] STARVE_ONE = 1;
    logic [SW-1:0] r_starve;

    assign w_force1 = (r_starve >= STARVE_MAX);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_starve <= '0;
        end else if (!req1_rd_i || req1_accept_o) begin
            r_starve <= '0;
        end else if (req0_accept_o && !w_force1) begin
            r_starve <= r_starve + STARVE_ONE;
        end
    end
`else
    assign w_force1 = 1'b0;
`endif

`ifndef SYNTHESIS
    assert property (@(posedge clk_i) disable iff (rst_i) !(icache_valid_i && (r_count == '0)))
        else $warning("biriscv_icache_arb: icache response with no reads in flight dropped");
`endif
endmodule

// File: tb/tb_biriscv_icache_arb.sv
// Directed bench for biriscv_icache_arb: response scoreboard plus per-cycle grant checks.
module tb_biriscv_icache_arb;
    logic        clk = 1'b0;
    logic        rst;
    logic        req0_rd, req1_rd;
    logic [31:0] req0_pc, req1_pc;
    logic [1:0]  req0_priv, req1_priv;
    logic        req0_accept, req0_valid, req1_accept, req1_valid;
    logic [63:0] resp_inst;
    logic        resp_error, resp_pf;
    logic        flush_req, inv_req, maint_busy;
    logic        ic_rd;
    logic [31:0] ic_pc;
    logic [1:0]  ic_priv;
    logic        ic_accept, ic_valid;
    logic [63:0] ic_inst;
    logic        ic_error, ic_pf, ic_flush, ic_inv;

    typedef struct packed {
        logic        port;
        logic [63:0] inst;
        logic        err;
        logic        pf;
    } resp_t;

    resp_t exp_q[$];
    resp_t mon_e;
    int n_pass  = 0;
    int n_total = 0;
    bit [9:0] grant_pat;

    biriscv_icache_arb dut (
        .clk_i(clk), .rst_i(rst),
        .req0_rd_i(req0_rd), .req0_pc_i(req0_pc), .req0_priv_i(req0_priv),
        .req0_accept_o(req0_accept), .req0_valid_o(req0_valid),
        .req1_rd_i(req1_rd), .req1_pc_i(req1_pc), .req1_priv_i(req1_priv),
        .req1_accept_o(req1_accept), .req1_valid_o(req1_valid),
        .resp_inst_o(resp_inst), .resp_error_o(resp_error), .resp_page_fault_o(resp_pf),
        .flush_req_i(flush_req), .invalidate_req_i(inv_req), .maint_busy_o(maint_busy),
        .icache_rd_o(ic_rd), .icache_pc_o(ic_pc), .icache_priv_o(ic_priv),
        .icache_accept_i(ic_accept), .icache_valid_i(ic_valid), .icache_inst_i(ic_inst),
        .icache_error_i(ic_error), .icache_page_fault_i(ic_pf),
        .icache_flush_o(ic_flush), .icache_invalidate_o(ic_inv)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic drive_resp(input logic port, input logic [63:0] inst, input logic err, input logic pf);
        ic_valid = 1'b1;
        ic_inst  = inst;
        ic_error = err;
        ic_pf    = pf;
        exp_q.push_back({port, inst, err, pf});
    endtask

    task automatic resp_off();
        ic_valid = 1'b0;
        ic_inst  = 64'h0;
        ic_error = 1'b0;
        ic_pf    = 1'b0;
    endtask

    function automatic logic [12:0] out_bundle();
        return {ic_rd, req0_accept, req1_accept, req0_valid, req1_valid, resp_error, resp_pf,
                maint_busy, ic_flush, ic_inv, |ic_pc, |ic_priv, |resp_inst};
    endfunction

    // Scoreboard monitor: every routed response must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && (req0_valid || req1_valid)) begin
            if (exp_q.size() == 0) begin
                check("resp_unexpected", 64'd1, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                $display("resp port=%0d inst=%h err=%0d pf=%0d", req1_valid, resp_inst, resp_error, resp_pf);
                check("resp_both_valid", 64'(req0_valid & req1_valid), 64'd0);
                check("resp_port", 64'(req1_valid), 64'(mon_e.port));
                check("resp_inst", resp_inst, mon_e.inst);
                check("resp_err", 64'(resp_error), 64'(mon_e.err));
                check("resp_pf", 64'(resp_pf), 64'(mon_e.pf));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        req0_rd = 0; req1_rd = 0; req0_pc = 0; req1_pc = 0; req0_priv = 0; req1_priv = 0;
        flush_req = 0; inv_req = 0; ic_accept = 0;
        resp_off();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        mid();
        check("reset_outputs", 64'(out_bundle()), 64'd0);

        // Same-cycle requests: port 0 wins, port 1 next; then FIFO full holds a third.
        cyc(); req0_rd = 1; req0_pc = 32'h8000_0000; req0_priv = 2'd3;
               req1_rd = 1; req1_pc = 32'h8000_0040; req1_priv = 2'd1; ic_accept = 1;
        mid(); check("prio_acc0", 64'(req0_accept), 64'd1);
               check("prio_acc1", 64'(req1_accept), 64'd0);
               check("prio_pc", 64'(ic_pc), 64'h8000_0000);
               check("prio_priv", 64'(ic_priv), 64'd3);
        cyc(); req0_rd = 0;
        mid(); check("second_acc1", 64'(req1_accept), 64'd1);
               check("second_pc", 64'(ic_pc), 64'h8000_0040);
               check("second_priv", 64'(ic_priv), 64'd1);
        cyc(); req1_rd = 0; req0_rd = 1; req0_pc = 32'h8000_0080;
        mid(); check("full_rd", 64'(ic_rd), 64'd0);
               check("full_acc0", 64'(req0_accept), 64'd0);
        cyc(); req0_rd = 0; ic_accept = 0; drive_resp(1'b0, 64'h1111_0000_AAAA_0001, 1'b0, 1'b0);
        cyc(); drive_resp(1'b1, 64'h2222_0000_BBBB_0002, 1'b1, 1'b1);
        cyc(); resp_off();

        // Stalled port-1 request keeps the grant while port 0 rises.
        cyc(); req1_rd = 1; req1_pc = 32'h8000_1000; req1_priv = 2'd2;
        mid(); check("lock_rd", 64'(ic_rd), 64'd1);
               check("lock_pc0", 64'(ic_pc), 64'h8000_1000);
               check("lock_acc1", 64'(req1_accept), 64'd0);
        for (int i = 0; i < 2; i++) begin
            cyc(); req0_rd = 1; req0_pc = 32'h8000_2000;
            mid(); check("lock_pc", 64'(ic_pc), 64'h8000_1000);
                   check("lock_acc0", 64'(req0_accept), 64'd0);
        end
        cyc(); ic_accept = 1;
        mid(); check("lock_release_acc1", 64'(req1_accept), 64'd1);
               check("lock_release_pc", 64'(ic_pc), 64'h8000_1000);
        cyc(); req1_rd = 0;
        mid(); check("after_lock_acc0", 64'(req0_accept), 64'd1);
               check("after_lock_pc", 64'(ic_pc), 64'h8000_2000);
        cyc(); req0_rd = 0; ic_accept = 0; drive_resp(1'b1, 64'h3333_0000_CCCC_0003, 1'b0, 1'b1);
        cyc(); drive_resp(1'b0, 64'h4444_0000_DDDD_0004, 1'b1, 1'b0);
        cyc(); resp_off();

        // Reset with two reads in flight; the late response must be dropped.
        cyc(); req0_rd = 1; req0_pc = 32'h8000_3000; ic_accept = 1;
        mid(); check("preflight_acc0", 64'(req0_accept), 64'd1);
        cyc(); req0_pc = 32'h8000_3008;
        cyc(); rst = 1; req0_rd = 0; ic_accept = 0;
        cyc(); rst = 0; ic_valid = 1; ic_inst = 64'hDEAD_BEEF_DEAD_BEEF;
        mid(); check("midflight_reset_outputs", 64'(out_bundle()), 64'd0);
        cyc(); resp_off(); req0_rd = 1; req0_pc = 32'h8000_3100; ic_accept = 1;
        mid(); check("post_reset_acc_a", 64'(req0_accept), 64'd1);
        cyc();
        mid(); check("post_reset_acc_b", 64'(req0_accept), 64'd1);
        cyc();
        mid(); check("post_reset_full", 64'(req0_accept), 64'd0);
        cyc(); req0_rd = 0; ic_accept = 0; drive_resp(1'b0, 64'h5555_0000_0000_0005, 1'b0, 1'b0);
        cyc(); drive_resp(1'b0, 64'h5555_0000_0000_0006, 1'b0, 1'b0);
        cyc(); resp_off();

        // Flush with two reads in flight: waits for both responses, then one pulse.
        cyc(); req0_rd = 1; req0_pc = 32'h8000_4000; ic_accept = 1;
        cyc();
        cyc(); flush_req = 1;
        mid(); check("flush_busy_latch", 64'(maint_busy), 64'd1);
               check("flush_no_rd0", 64'(ic_rd), 64'd0);
        cyc(); flush_req = 0;
        mid(); check("drain_flush0", 64'(ic_flush), 64'd0);
               check("drain_rd", 64'(ic_rd), 64'd0);
               check("drain_busy", 64'(maint_busy), 64'd1);
        cyc(); drive_resp(1'b0, 64'h7777_0000_0000_0007, 1'b0, 1'b0);
        mid(); check("drain_flush1", 64'(ic_flush), 64'd0);
               check("drain_rd1", 64'(ic_rd), 64'd0);
        cyc(); drive_resp(1'b0, 64'h7777_0000_0000_0008, 1'b0, 1'b0);
        mid(); check("drain_flush2", 64'(ic_flush), 64'd0);
        cyc(); resp_off();
        mid(); check("drain_flush3", 64'(ic_flush), 64'd0);
               check("drain_rd3", 64'(ic_rd), 64'd0);
        cyc();
        mid(); check("flush_pulse", 64'({ic_flush, ic_inv}), 64'b10);
               check("flush_pulse_rd", 64'(ic_rd), 64'd0);
        cyc();
        mid(); check("flush_done", 64'({ic_flush, ic_inv, maint_busy}), 64'd0);
               check("flush_resume_acc0", 64'(req0_accept), 64'd1);
        cyc(); req0_rd = 0; ic_accept = 0; drive_resp(1'b0, 64'h7777_0000_0000_0009, 1'b0, 1'b0);
        cyc(); resp_off();

        // Flush and invalidate together pulse in the same cycle.
        cyc(); flush_req = 1; inv_req = 1;
        mid(); check("maint2_busy", 64'(maint_busy), 64'd1);
        cyc(); flush_req = 0; inv_req = 0;
        mid(); check("maint2_wait", 64'({ic_flush, ic_inv, maint_busy}), 64'b001);
        cyc();
        mid(); check("maint2_pulse", 64'({ic_flush, ic_inv}), 64'b11);
        cyc();
        mid(); check("maint2_done", 64'({ic_flush, ic_inv, maint_busy}), 64'd0);

        // Both ports requesting continuously with every read accepted.
`ifdef ICACHE_ARB_FAIRNESS_EN
        grant_pat = 10'b10_0001_0000;
`else
        grant_pat = 10'b00_0000_0000;
`endif
        for (int k = 0; k < 10; k++) begin
            cyc(); req0_rd = 1; req0_pc = 32'h8000_5000; req1_rd = 1; req1_pc = 32'h8000_5040; ic_accept = 1;
            if (k > 0) drive_resp(grant_pat[k-1], 64'h6000 + 64'(k), 1'b0, 1'b0);
            mid();
            $display("grant cycle=%0d port=%0d", k, req1_accept);
            check("fair_grant", 64'(req1_accept), 64'(grant_pat[k]));
            check("fair_taken", 64'(req0_accept | req1_accept), 64'd1);
        end
        cyc(); req0_rd = 0; req1_rd = 0; ic_accept = 0; drive_resp(grant_pat[9], 64'h6000 + 64'd10, 1'b0, 1'b0);
        cyc(); resp_off();

        repeat (3) cyc();
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
